// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiters.
// rr_pick does a wrap-around first-set search starting at a rotating pointer.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  localparam int unsigned MAX_REQ = 8;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Returns {found, idx}; ptr must be below n, so one wrap subtraction suffices.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
    logic [3:0]  res;
    int unsigned c;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      c = {29'd0, ptr} + k;
      if (c >= n) c = c - n;
      if (k < n && !res[3] && valid[c[2:0]]) res = {1'b1, c[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin selector: first valid requester at or above ptr_i,
// wrapping modulo N. IDs >= N are never returned.
module rr_priority_sel
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   valid_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [2:0]         ptr_ext;
  logic [3:0]         pick;

  always_comb begin
    valid_ext          = '0;
    valid_ext[N-1:0]   = valid_i;
    ptr_ext            = '0;
    ptr_ext[IDW-1:0]   = ptr_i;
    pick               = rr_pick(valid_ext, ptr_ext, N);
    found_o            = pick[3];
    idx_o              = IDW'(pick[2:0]);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin sharing of one FIFO_HS write port among N_REQ
// requesters; each written word is tagged with the winner's ID.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned WIDTH = 179,
  localparam int unsigned ID_W  = id_width(N_REQ)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [ID_W+WIDTH-1:0]  fifo_data,
  output logic                   busy,
  output logic [ID_W-1:0]        owner,
  output logic [15:0]            beat_cnt
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [15:0]     beat_cnt_q, beat_cnt_d;

  logic            sel_found;
  logic [ID_W-1:0] sel_idx;
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic            xfer;

  rr_priority_sel #(
    .N   (N_REQ),
    .IDW (ID_W)
  ) u_sel (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    grant_vld  = 1'b0;
    grant_idx  = owner_q;
    req_ready  = '0;

    if (state_q == LOCKED) begin
      grant_vld = 1'b1;
    end else if (sel_found) begin
      grant_vld = 1'b1;
      grant_idx = sel_idx;
    end

    // Reset gating keeps the write port quiet even though IDLE would grant.
    if (grant_vld && !fifo_full && !Reset) req_ready[grant_idx] = 1'b1;
    xfer = |(req_valid & req_ready);

    fifo_wr_en = xfer;
    fifo_data  = {grant_idx, req_data[grant_idx*WIDTH +: WIDTH]};

    if (xfer) begin
      owner_d = grant_idx;
      if (beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;
      if (req_last[grant_idx]) begin
        state_d  = IDLE;
        rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        state_d = LOCKED;
      end
    end
  end

  assign busy     = (state_q == LOCKED);
  assign owner    = owner_q;
  assign beat_cnt = beat_cnt_q;

endmodule
